// File: rtl/lsu_align_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// lsu_align_pkg : access-size codes and FSM encodings for the LSU aligner
// Rev 1.0
// ----------------------------------------------------------------------------
package lsu_align_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BEAT0 = 2'd1;
  localparam logic [1:0] ST_BEAT1 = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  function automatic int size_bytes(input logic [1:0] size);
    return 1 << size;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_align_be_mask.sv
`default_nettype none
// ----------------------------------------------------------------------------
// be_mask : byte-enable mask over two consecutive bus words, with split and
//           illegal-size flags.  Rev 1.0
// ----------------------------------------------------------------------------
module be_mask
  import lsu_align_pkg::*;
#(
  parameter int NB = 4
) (
  input  logic [1:0]            size,
  input  logic [$clog2(NB)-1:0] off,
  output logic [2*NB-1:0]       mask,
  output logic                  split,
  output logic                  illegal
);

  int nbytes;
  assign nbytes = size_bytes(size);

  always_comb begin
    mask = '0;
    for (int i = 0; i < 2*NB; i++) begin
      mask[i] = (i >= int'(off)) && (i < int'(off) + nbytes);
    end
  end

  assign illegal = (nbytes > NB);
  assign split   = !illegal && (|mask[2*NB-1:NB]);

endmodule
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ----------------------------------------------------------------------------
// lsu_align : load/store alignment unit; lane-rotates store data, splits or
//             rejects misaligned accesses, extracts and extends load data.
// Rev 1.0
// ----------------------------------------------------------------------------
module lsu_align
  import lsu_align_pkg::*;
#(
  parameter int DW    = 32,
  parameter int AW    = 32,
  parameter bit SPLIT = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [1:0]      req_size,
  input  logic            req_signed,
  input  logic [AW-1:0]   req_addr,
  input  logic [DW-1:0]   req_wdata,
  output logic            rsp_valid,
  output logic [DW-1:0]   rsp_rdata,
  output logic            rsp_err,
  output logic            bus_req,
  output logic            bus_we,
  output logic [AW-1:0]   bus_addr,
  output logic [DW/8-1:0] bus_be,
  output logic [DW-1:0]   bus_wdata,
  input  logic            bus_ack,
  input  logic [DW-1:0]   bus_rdata
);

  localparam int NB = DW / 8;
  localparam int OW = $clog2(NB);

  logic [1:0]    r_state;
  logic          r_we;
  logic          r_signed;
  logic          r_err;
  logic          r_split;
  logic [1:0]    r_size;
  logic [OW-1:0] r_off;
  logic [NB-1:0] r_mask_hi;
  logic [DW-1:0] r_buf;

  logic [OW-1:0]   w_off;
  logic [AW-1:0]   w_base;
  logic [2*NB-1:0] w_mask;
  logic            w_split;
  logic            w_illegal;
  logic [DW-1:0]   w_wrot;
  logic [DW-1:0]   w_buf_next;
  logic [DW-1:0]   w_rot;
  logic [DW-1:0]   w_ext;
  logic            w_sign;
  int              w_nbytes;

  assign w_off  = req_addr[OW-1:0];
  assign w_base = {req_addr[AW-1:OW], {OW{1'b0}}};

  be_mask #(.NB(NB)) u_be_mask (
    .size    (req_size),
    .off     (w_off),
    .mask    (w_mask),
    .split   (w_split),
    .illegal (w_illegal)
  );

  // Store byte i lands on lane (i+off) mod NB; both beats share this word.
  always_comb begin
    w_wrot = '0;
    for (int l = 0; l < NB; l++) begin
      w_wrot[8*l +: 8] = req_wdata[8*((l + NB - int'(w_off)) % NB) +: 8];
    end
  end

  always_comb begin
    w_buf_next = r_buf;
    for (int l = 0; l < NB; l++) begin
      if (bus_be[l]) w_buf_next[8*l +: 8] = bus_rdata[8*l +: 8];
    end
  end

  // Beats never overlap in lanes, so one NB-byte buffer rotated by off suffices.
  assign w_nbytes = size_bytes(r_size);

  always_comb begin
    w_rot  = '0;
    w_sign = 1'b0;
    for (int j = 0; j < NB; j++) begin
      w_rot[8*j +: 8] = r_buf[8*((j + int'(r_off)) % NB) +: 8];
    end
    for (int j = 0; j < NB; j++) begin
      if (j == w_nbytes - 1) w_sign = w_rot[8*j + 7];
    end
  end

  always_comb begin
    w_ext = '0;
    for (int j = 0; j < NB; j++) begin
      w_ext[8*j +: 8] = (j < w_nbytes) ? w_rot[8*j +: 8] : {8{r_signed & w_sign}};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_we      <= 1'b0;
      r_signed  <= 1'b0;
      r_err     <= 1'b0;
      r_split   <= 1'b0;
      r_size    <= SZ_B;
      r_off     <= '0;
      r_mask_hi <= '0;
      r_buf     <= '0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_be    <= '0;
      bus_wdata <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_we      <= req_we;
            r_signed  <= req_signed;
            r_size    <= req_size;
            r_off     <= w_off;
            r_mask_hi <= w_mask[2*NB-1:NB];
            r_split   <= w_split;
            r_buf     <= '0;
            if (w_illegal || (w_split && !SPLIT)) begin
              r_err   <= 1'b1;
              r_state <= ST_RESP;
            end else begin
              r_err     <= 1'b0;
              r_state   <= ST_BEAT0;
              bus_we    <= req_we;
              bus_addr  <= w_base;
              bus_be    <= w_mask[NB-1:0];
              bus_wdata <= w_wrot;
            end
          end
        end
        ST_BEAT0: begin
          if (bus_ack) begin
            r_buf <= w_buf_next;
            if (r_split) begin
              r_state  <= ST_BEAT1;
              bus_addr <= bus_addr + AW'(NB);
              bus_be   <= r_mask_hi;
            end else begin
              r_state <= ST_RESP;
              bus_be  <= '0;
              bus_we  <= 1'b0;
            end
          end
        end
        ST_BEAT1: begin
          if (bus_ack) begin
            r_buf   <= w_buf_next;
            r_state <= ST_RESP;
            bus_be  <= '0;
            bus_we  <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready = (r_state == ST_IDLE);
  assign bus_req   = (r_state == ST_BEAT0) || (r_state == ST_BEAT1);
  assign rsp_valid = (r_state == ST_RESP);
  assign rsp_err   = rsp_valid & r_err;
  assign rsp_rdata = (rsp_valid && !r_err && !r_we) ? w_ext : '0;

endmodule
`default_nettype wire

// File: tb/tb_lsu_align.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_lsu_align : self-checking bench for lsu_align (32-bit split, 32-bit
//                no-split and 64-bit split instances).  Rev 1.0
// ----------------------------------------------------------------------------
module tb_lsu_align;
  import lsu_align_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  // ---------------- 32-bit, SPLIT=1 instance ----------------
  logic        a_req_valid = 0, a_req_we = 0, a_req_signed = 0;
  logic [1:0]  a_req_size = 0;
  logic [31:0] a_req_addr = 0, a_req_wdata = 0;
  logic        a_req_ready, a_rsp_valid, a_rsp_err, a_bus_req, a_bus_we;
  logic [31:0] a_rsp_rdata, a_bus_addr, a_bus_wdata;
  logic [3:0]  a_bus_be;
  logic        a_bus_ack;
  logic [31:0] a_bus_rdata;

  lsu_align #(.DW(32), .AW(32), .SPLIT(1'b1)) u_a (
    .clk(clk), .rst_n(rst_n),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
    .req_size(a_req_size), .req_signed(a_req_signed), .req_addr(a_req_addr),
    .req_wdata(a_req_wdata), .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata),
    .rsp_err(a_rsp_err), .bus_req(a_bus_req), .bus_we(a_bus_we),
    .bus_addr(a_bus_addr), .bus_be(a_bus_be), .bus_wdata(a_bus_wdata),
    .bus_ack(a_bus_ack), .bus_rdata(a_bus_rdata)
  );

  // ---------------- 32-bit, SPLIT=0 instance ----------------
  logic        n_req_valid = 0, n_req_we = 0, n_req_signed = 0;
  logic [1:0]  n_req_size = 0;
  logic [31:0] n_req_addr = 0, n_req_wdata = 0;
  logic        n_req_ready, n_rsp_valid, n_rsp_err, n_bus_req, n_bus_we;
  logic [31:0] n_rsp_rdata, n_bus_addr, n_bus_wdata;
  logic [3:0]  n_bus_be;
  logic        n_bus_ack;
  logic [31:0] n_bus_rdata;
  logic        n_seen = 1'b0;

  assign n_bus_ack   = n_bus_req;
  assign n_bus_rdata = 32'hCAFE_BABE;
  always @(posedge n_bus_req) n_seen <= 1'b1;

  lsu_align #(.DW(32), .AW(32), .SPLIT(1'b0)) u_n (
    .clk(clk), .rst_n(rst_n),
    .req_valid(n_req_valid), .req_ready(n_req_ready), .req_we(n_req_we),
    .req_size(n_req_size), .req_signed(n_req_signed), .req_addr(n_req_addr),
    .req_wdata(n_req_wdata), .rsp_valid(n_rsp_valid), .rsp_rdata(n_rsp_rdata),
    .rsp_err(n_rsp_err), .bus_req(n_bus_req), .bus_we(n_bus_we),
    .bus_addr(n_bus_addr), .bus_be(n_bus_be), .bus_wdata(n_bus_wdata),
    .bus_ack(n_bus_ack), .bus_rdata(n_bus_rdata)
  );

  // ---------------- 64-bit, SPLIT=1 instance ----------------
  logic        d_req_valid = 0, d_req_we = 0, d_req_signed = 0;
  logic [1:0]  d_req_size = 0;
  logic [31:0] d_req_addr = 0;
  logic [63:0] d_req_wdata = 0;
  logic        d_req_ready, d_rsp_valid, d_rsp_err, d_bus_req, d_bus_we;
  logic [63:0] d_rsp_rdata, d_bus_wdata;
  logic [31:0] d_bus_addr;
  logic [7:0]  d_bus_be;
  logic        d_bus_ack;
  logic [63:0] d_bus_rdata;

  assign d_bus_ack   = d_bus_req;
  assign d_bus_rdata = 64'h8877_6655_4433_2211;

  lsu_align #(.DW(64), .AW(32), .SPLIT(1'b1)) u_d (
    .clk(clk), .rst_n(rst_n),
    .req_valid(d_req_valid), .req_ready(d_req_ready), .req_we(d_req_we),
    .req_size(d_req_size), .req_signed(d_req_signed), .req_addr(d_req_addr),
    .req_wdata(d_req_wdata), .rsp_valid(d_rsp_valid), .rsp_rdata(d_rsp_rdata),
    .rsp_err(d_rsp_err), .bus_req(d_bus_req), .bus_we(d_bus_we),
    .bus_addr(d_bus_addr), .bus_be(d_bus_be), .bus_wdata(d_bus_wdata),
    .bus_ack(d_bus_ack), .bus_rdata(d_bus_rdata)
  );

  // ---------------- model state for the 32-bit split instance ----------------
  logic [7:0]  mem [0:1023];
  int          ack_dly = 0;
  int          scnt = 0;
  int          nbeats = 0, beat_idx = 0, exp_lat = 0, acc_edge = 0;
  logic [31:0] exp_addr [2];
  logic [3:0]  exp_be [2];
  logic [31:0] exp_wdata = 0, exp_rdata = 0;
  logic        exp_we = 0, exp_err = 0;
  logic        busy = 0, got_rsp = 0, chk_en = 0;
  logic [31:0] last_wdata0 = 0, last_addr0 = 0, last_rdata = 0;
  logic [3:0]  last_be0 = 0, last_be1 = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, want, $time);
    end
  endtask

  // Bus slave: byte memory, programmable wait cycles per beat
  initial begin
    a_bus_ack   = 1'b0;
    a_bus_rdata = '0;
    forever begin
      @(negedge clk);
      if (a_bus_req === 1'b1) begin
        if (scnt >= ack_dly) begin
          a_bus_ack = 1'b1;
          scnt = 0;
          for (int l = 0; l < 4; l++) begin
            a_bus_rdata[8*l +: 8] = mem[int'(a_bus_addr) + l];
            if (a_bus_we && a_bus_be[l]) mem[int'(a_bus_addr) + l] = a_bus_wdata[8*l +: 8];
          end
        end else begin
          a_bus_ack   = 1'b0;
          a_bus_rdata = '0;
          scnt++;
        end
      end else begin
        a_bus_ack = 1'b0;
        scnt = 0;
      end
    end
  end

  // Per-cycle comparison of the 32-bit split instance against the model
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (chk_en) begin
        chk("req_ready", a_req_ready, !busy);
        if (a_bus_req) begin
          if (beat_idx >= nbeats) begin
            chk("unexpected_bus_req", a_bus_req, 1'b0);
          end else begin
            chk("bus_addr", a_bus_addr, exp_addr[beat_idx]);
            chk("bus_be", a_bus_be, exp_be[beat_idx]);
            chk("bus_we", a_bus_we, exp_we);
            if (exp_we) chk("bus_wdata", a_bus_wdata, exp_wdata);
            if (beat_idx == 0) begin
              last_wdata0 = a_bus_wdata;
              last_addr0  = a_bus_addr;
              last_be0    = a_bus_be;
            end else begin
              last_be1 = a_bus_be;
            end
            if (a_bus_ack) beat_idx++;
          end
        end
        if (a_rsp_valid) begin
          if (!busy) begin
            chk("unexpected_rsp", a_rsp_valid, 1'b0);
          end else begin
            chk("rsp_err", a_rsp_err, exp_err);
            chk("rsp_rdata", a_rsp_rdata, exp_rdata);
            chk("rsp_latency", cyc - acc_edge + 1, exp_lat);
            chk("beats_done", beat_idx, nbeats);
            last_rdata = a_rsp_rdata;
            got_rsp = 1'b1;
            busy    = 1'b0;
          end
        end
      end
    end
  end

  task automatic access32(input logic we, input logic [1:0] sz, input logic sg,
                          input logic [31:0] addr, input logic [31:0] wd, input int dly);
    int n, off, t;
    n   = 1 << sz;
    off = int'(addr % 4);
    ack_dly = dly;
    exp_we  = we;
    exp_err = (n > 4);
    nbeats  = exp_err ? 0 : ((off + n > 4) ? 2 : 1);
    for (int b = 0; b < 2; b++) begin
      exp_addr[b] = (addr & ~32'h3) + 32'(4 * b);
      exp_be[b]   = '0;
      for (int k = 0; k < n; k++) begin
        if ((off + k) / 4 == b) exp_be[b][(off + k) % 4] = 1'b1;
      end
    end
    for (int l = 0; l < 4; l++) exp_wdata[8*l +: 8] = wd[8*((l - off + 4) % 4) +: 8];
    exp_rdata = '0;
    if (!we && !exp_err) begin
      for (int k = 0; k < n; k++) exp_rdata[8*k +: 8] = mem[int'(addr) + k];
      if (sg && exp_rdata[8*n - 1]) begin
        for (int k = n; k < 4; k++) exp_rdata[8*k +: 8] = 8'hFF;
      end
    end
    exp_lat  = exp_err ? 1 : nbeats * (dly + 1) + 1;
    beat_idx = 0;
    got_rsp  = 1'b0;
    @(negedge clk);
    a_req_we = we; a_req_size = sz; a_req_signed = sg;
    a_req_addr = addr; a_req_wdata = wd; a_req_valid = 1'b1;
    @(posedge clk);
    #1;
    acc_edge = cyc;
    busy = 1'b1;
    a_req_valid = 1'b0;
    t = 0;
    while (!got_rsp && t < 60) begin
      @(negedge clk);
      #3;
      t++;
    end
    if (!got_rsp) begin
      chk("rsp_timeout", 1'b0, 1'b1);
      busy = 1'b0;
    end
  endtask

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'(i * 37 + 11);
    mem[0] = 8'h00; mem[1] = 8'h00; mem[2] = 8'h80; mem[3] = 8'h00;

    // Reset values while rst_n is held low
    #3;
    chk("rst_ready", a_req_ready, 1'b1);
    chk("rst_bus_req", a_bus_req, 1'b0);
    chk("rst_bus_be", a_bus_be, 4'h0);
    chk("rst_bus_we", a_bus_we, 1'b0);
    chk("rst_bus_addr", a_bus_addr, 32'h0);
    chk("rst_bus_wdata", a_bus_wdata, 32'h0);
    chk("rst_rsp_valid", a_rsp_valid, 1'b0);
    chk("rst_rsp_rdata", a_rsp_rdata, 32'h0);
    chk("rst_rsp_err", a_rsp_err, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1'b1;

    // Store byte at 0x103
    access32(1'b1, SZ_B, 1'b0, 32'h103, 32'h0000_00A5, 0);
    chk("lit_sb_addr", last_addr0, 32'h100);
    chk("lit_sb_be", last_be0, 4'b1000);
    chk("lit_sb_lane3", last_wdata0[31:24], 8'hA5);

    // Load byte at 0x2, signed and unsigned
    access32(1'b0, SZ_B, 1'b1, 32'h2, 32'h0, 0);
    chk("lit_lb_signed", last_rdata, 32'hFFFF_FF80);
    access32(1'b0, SZ_B, 1'b0, 32'h2, 32'h0, 0);
    chk("lit_lb_unsigned", last_rdata, 32'h0000_0080);

    // Split store word at 0x101, then reassembling load
    access32(1'b1, SZ_W, 1'b0, 32'h101, 32'h1122_3344, 0);
    chk("lit_sw_wdata", last_wdata0, 32'h2233_4411);
    chk("lit_sw_be0", last_be0, 4'b1110);
    chk("lit_sw_be1", last_be1, 4'b0001);
    access32(1'b0, SZ_W, 1'b0, 32'h101, 32'h0, 0);
    chk("lit_lw_split", last_rdata, 32'h1122_3344);

    // Doubleword on a 32-bit bus is illegal
    access32(1'b0, SZ_D, 1'b0, 32'h10, 32'h0, 0);

    // Three wait cycles per beat on a split halfword
    access32(1'b1, SZ_H, 1'b0, 32'h203, 32'h0000_8001, 3);
    access32(1'b0, SZ_H, 1'b1, 32'h203, 32'h0, 3);
    chk("lit_lh_wait", last_rdata, 32'hFFFF_8001);

    // Sweep of offsets and sizes, alternating zero/one wait cycle
    for (int o = 0; o < 4; o++) begin
      for (int s = 0; s < 3; s++) begin
        access32(1'b0, s[1:0], o[0], 32'h80 + 32'(o), 32'h0, o % 2);
      end
    end

    // Reset pulsed while beat 1 is waiting for its ack
    chk_en = 1'b0;
    ack_dly = 0;
    @(negedge clk);
    a_req_we = 1'b1; a_req_size = SZ_W; a_req_signed = 1'b0;
    a_req_addr = 32'h301; a_req_wdata = 32'hDEAD_BEEF; a_req_valid = 1'b1;
    @(posedge clk);
    #1 a_req_valid = 1'b0;
    @(negedge clk);
    #3 ack_dly = 20;
    @(negedge clk);
    #3;
    chk("rst_mid_bus_req", a_bus_req, 1'b1);
    chk("rst_mid_be1", a_bus_be, 4'b0001);
    rst_n = 1'b0;
    #1;
    chk("rst_async_bus_req", a_bus_req, 1'b0);
    chk("rst_async_ready", a_req_ready, 1'b1);
    chk("rst_async_be", a_bus_be, 4'h0);
    @(negedge clk);
    rst_n = 1'b1;
    ack_dly = 0;
    repeat (4) begin
      @(negedge clk);
      #2;
      chk("rst_no_rsp", a_rsp_valid, 1'b0);
    end
    chk("rst_release_ready", a_req_ready, 1'b1);
    busy = 1'b0;
    chk_en = 1'b1;

    // SPLIT=0: misaligned half -> error at T+1, no bus beat
    @(negedge clk);
    n_seen = 1'b0;
    n_req_we = 1'b0; n_req_size = SZ_H; n_req_addr = 32'h3; n_req_valid = 1'b1;
    @(posedge clk);
    #1 n_req_valid = 1'b0;
    @(negedge clk);
    #2;
    chk("ns_err_valid", n_rsp_valid, 1'b1);
    chk("ns_err_flag", n_rsp_err, 1'b1);
    chk("ns_err_rdata", n_rsp_rdata, 32'h0);
    @(negedge clk);
    #2;
    chk("ns_no_bus_req", n_seen, 1'b0);
    chk("ns_ready_after", n_req_ready, 1'b1);
    // SPLIT=0: doubleword -> error
    n_req_size = SZ_D; n_req_addr = 32'h8; n_req_valid = 1'b1;
    @(posedge clk);
    #1 n_req_valid = 1'b0;
    @(negedge clk);
    #2;
    chk("ns_d_err", n_rsp_err, 1'b1);
    // SPLIT=0: aligned word load still works
    @(negedge clk);
    n_req_size = SZ_W; n_req_addr = 32'h8; n_req_valid = 1'b1;
    @(posedge clk);
    #1 n_req_valid = 1'b0;
    @(negedge clk);
    #2;
    chk("ns_lw_be", n_bus_be, 4'hF);
    chk("ns_lw_addr", n_bus_addr, 32'h8);
    @(negedge clk);
    #2;
    chk("ns_lw_valid", n_rsp_valid, 1'b1);
    chk("ns_lw_err", n_rsp_err, 1'b0);
    chk("ns_lw_rdata", n_rsp_rdata, 32'hCAFE_BABE);

    // 64-bit: aligned store double at 0x8
    @(negedge clk);
    d_req_we = 1'b1; d_req_size = SZ_D; d_req_addr = 32'h8;
    d_req_wdata = 64'h0102_0304_0506_0708; d_req_valid = 1'b1;
    @(posedge clk);
    #1 d_req_valid = 1'b0;
    @(negedge clk);
    #2;
    chk("d_sd_req", d_bus_req, 1'b1);
    chk("d_sd_be", d_bus_be, 8'hFF);
    chk("d_sd_addr", d_bus_addr, 32'h8);
    chk("d_sd_wdata", d_bus_wdata, 64'h0102_0304_0506_0708);
    @(negedge clk);
    #2;
    chk("d_sd_rsp", d_rsp_valid, 1'b1);
    chk("d_sd_err", d_rsp_err, 1'b0);
    // 64-bit: load double at 0x4 splits into two beats
    @(negedge clk);
    d_req_we = 1'b0; d_req_size = SZ_D; d_req_addr = 32'h4; d_req_valid = 1'b1;
    @(posedge clk);
    #1 d_req_valid = 1'b0;
    @(negedge clk);
    #2;
    chk("d_ld_be0", d_bus_be, 8'hF0);
    chk("d_ld_addr0", d_bus_addr, 32'h0);
    @(negedge clk);
    #2;
    chk("d_ld_be1", d_bus_be, 8'h0F);
    chk("d_ld_addr1", d_bus_addr, 32'h8);
    @(negedge clk);
    #2;
    chk("d_ld_rsp", d_rsp_valid, 1'b1);
    chk("d_ld_rdata", d_rsp_rdata, 64'h4433_2211_8877_6655);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lsu_align.md
# lsu_align

Parametrised load/store alignment unit for the multicycle MIPS core, sitting between the datapath's memory stage and the memory/UART bus. It generalises the byte-enable calculation to any power-of-two data width, including doubleword, and adds load-data extraction with sign/zero extension. With `SPLIT=1`, it splits misaligned accesses into two bus beats, driving each over a req/ack handshake. Each request produces exactly one response: either data or an error.

## Interface
- `DW`, 32: bus/data width in bits; 32 or 64.
- `AW`, 32: address width.
- `SPLIT`, 1: 1 = misaligned accesses split into two beats; 0 = misaligned access returns error.
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: CPU request strobe.
- `req_ready` out 1: unit idle, accepts request.
- `req_we` in 1: 1 = store, 0 = load.
- `req_size` in 2: `SZ_B`/`SZ_H`/`SZ_W`/`SZ_D` = 1/2/4/8 bytes.
- `req_signed` in 1: loads only; 1 = sign-extend, 0 = zero-extend.
- `req_addr` in AW: byte address.
- `req_wdata` in DW: store data, right-justified.
- `rsp_valid` out 1: one-cycle response pulse.
- `rsp_rdata` out DW: load result, extended; 0 for stores and errors.
- `rsp_err` out 1: illegal size or disallowed misalignment; valid with `rsp_valid`.
- `bus_req` out 1: bus beat request.
- `bus_we` out 1: beat is a write.
- `bus_addr` out AW: DW/8-aligned beat address.
- `bus_be` out DW/8: byte lane enables.
- `bus_wdata` out DW: lane-rotated write data.
- `bus_ack` in 1: beat complete; read data valid this cycle.
- `bus_rdata` in DW: read data.

## Operation
- Definitions:
  - NB = DW/8.
  - n = 1<<req_size.
  - off = req_addr mod NB.
  - base = req_addr with the low log2(NB) bits cleared.
  - mask = ((1<<n)-1)<<off, which is 2·NB bits wide.
- States: IDLE, BEAT0, BEAT1, RESP.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`, latch the request and compute mask.
  - `SZ_D` with DW=32 → RESP, err.
  - mask upper half zero → BEAT0, single beat.
  - Otherwise, with SPLIT=1 → BEAT0, split.
  - Otherwise, with SPLIT=0 → RESP, err.
- BEAT0:
  - `bus_req`=1, `bus_addr`=base, `bus_be`=mask[NB-1:0].
  - On `bus_ack`, capture the enabled lanes into the assembly buffer.
  - Next state is BEAT1 if split, else RESP.
- BEAT1:
  - `bus_req`=1, `bus_addr`=base+NB, `bus_be`=mask[2NB-1:NB].
  - On `bus_ack`, capture the enabled lanes, then → RESP.
- RESP:
  - `rsp_valid`=1 for exactly one cycle, then → IDLE.
- Write data: `req_wdata` is rotated left by off bytes (byte i → lane (i+off) mod NB). The same word is driven in both beats; `bus_be` selects the lanes.
- Read data: the assembly buffer is rotated right by off bytes and truncated to n bytes. It is then sign-extended from bit 8n-1 if `req_signed`, else zero-extended to DW.
- `bus_addr`, `bus_be`, `bus_we`, `bus_wdata` are held stable while `bus_req`=1 and the beat is unacked.
- `req_valid` is ignored outside IDLE.

## Timing
- Reset values (async, immediate):
  - state = IDLE, so `req_ready`=1.
  - `bus_req`=0, `bus_be`=0, `bus_we`=0, `bus_addr`=0, `bus_wdata`=0.
  - `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0.
- Reset during BEAT0/BEAT1/RESP: the beat is abandoned, no response is produced, and IDLE is entered on release.
- Accept at cycle T:
  - `bus_req` rises at T+1.
  - Zero-wait ack at T+1 gives `rsp_valid` at T+2 (single beat) or T+3 (split).
  - Each bus wait cycle adds one cycle.
- Error path: `rsp_valid`/`rsp_err` at T+1, and `bus_req` is never asserted.
- Back-to-back: the next request can be accepted in the cycle after RESP, so sustained throughput is at most one access per 3 cycles.
- All outputs are registered or decoded from state; there is no combinational path from `bus_ack` to `bus_req`.

## Structure
- Shared package: `ctrl_encode_def.v` gains `SZ_B`=2'b00, `SZ_H`=2'b01, `SZ_W`=2'b10, `SZ_D`=2'b11, and the state encodings.
- Sub-module: `be_mask`, a combinational block with parameter NB and inputs size and off. It outputs the 2·NB mask, a split flag and an illegal flag. `be_mask` is reused by the DMA path.

## Test plan
- DW=32, store byte at addr 0x103, wdata 0xA5 → one beat: `bus_addr`=0x100, `bus_be`=4'b1000, `bus_wdata`[31:24]=0xA5; `rsp_valid` at T+2, `rsp_err`=0.
- DW=32, load byte at addr 0x2, `bus_rdata`=0x0080_0000: signed → `rsp_rdata`=0xFFFF_FF80; unsigned → 0x0000_0080.
- DW=32, SPLIT=1, store word at addr 0x101, wdata 0x1122_3344:
  - beat0: `bus_addr`=0x100, `bus_be`=4'b1110, `bus_wdata`=0x2233_4411.
  - beat1: `bus_addr`=0x104, `bus_be`=4'b0001, same `bus_wdata`.
  - A load of the same address reassembles 0x1122_3344.
- DW=32, SPLIT=0, load half at addr 0x3 → `rsp_err`=1 at T+1, `bus_req` never asserted. Any `SZ_D` request → `rsp_err`=1.
- DW=64, store double at addr 0x8 → `bus_be`=8'hFF, single beat. Load double at addr 0x4 with SPLIT=1 → two beats, with `bus_be`=8'hF0 then 8'h0F.
- `bus_ack` delayed 3 cycles → bus outputs held stable throughout. `rst_n` pulsed low during BEAT1 → `bus_req`=0 immediately, no `rsp_valid`, and `req_ready`=1 after release.
